// File: rtl/lsu_port_arbiter.sv
// lsu_port_arbiter: shares one LSU port between the cpu MEM stage and an ext requester.
// Latency: combinational grant, registered mem_* command next cycle, rvalid RD_LAT+1 cycles after grant.
// Backpressure: cpu wins by default and stalls only when ext is forced after STARVE_LIMIT losses.
// Ports: clk_i/rst_i; cpu_*/ext_* request fields with gnt, rvalid and rdata back;
//   cpu_stall_o; mem_* registered LSU command; mem_rdata_i load data from the LSU.
module lsu_port_arbiter #(
   parameter int RD_LAT       = 1,
   parameter int STARVE_LIMIT = 4
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        cpu_req_i,
   input  logic        cpu_we_i,
   input  logic [31:0] cpu_addr_i,
   input  logic [31:0] cpu_wdata_i,
   input  logic [2:0]  cpu_mem_op_i,
   input  logic        ext_req_i,
   input  logic        ext_we_i,
   input  logic [31:0] ext_addr_i,
   input  logic [31:0] ext_wdata_i,
   input  logic [2:0]  ext_mem_op_i,
   output logic        cpu_gnt_o,
   output logic        ext_gnt_o,
   output logic        cpu_stall_o,
   output logic        cpu_rvalid_o,
   output logic        ext_rvalid_o,
   output logic [31:0] cpu_rdata_o,
   output logic [31:0] ext_rdata_o,
   output logic        mem_req_o,
   output logic        mem_we_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_wdata_o,
   output logic [2:0]  mem_op_o,
   input  logic [31:0] mem_rdata_i
);

   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   logic [3:0]        starve_cnt;
   logic              force_ext;
   logic              cpu_gnt;
   logic              ext_gnt;
   logic              load_issue;
   // tag_vld/tag_own: one slot per cycle of LSU read latency; own = 1 means ext
   logic [RD_LAT-1:0] tag_vld;
   logic [RD_LAT-1:0] tag_own;
   logic              cpu_rvalid_q;
   logic              ext_rvalid_q;
   logic [31:0]       cpu_rdata_q;
   logic [31:0]       ext_rdata_q;

   // ext is pushed through only once it has lost STARVE_LIMIT times in a row
   assign force_ext  = ext_req_i & (starve_cnt == LIMIT);
   assign cpu_gnt    = ~rst_i & cpu_req_i & ~force_ext;
   assign ext_gnt    = ~rst_i & ext_req_i & (~cpu_req_i | force_ext);
   assign load_issue = (cpu_gnt & ~cpu_we_i) | (ext_gnt & ~ext_we_i);

   assign cpu_gnt_o   = cpu_gnt;
   assign ext_gnt_o   = ext_gnt;
   assign cpu_stall_o = ~rst_i & cpu_req_i & ~cpu_gnt;

   // Starvation counter: counts consecutive cpu wins while ext waits
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         starve_cnt <= '0;
      end else if (ext_gnt | ~ext_req_i) begin
         starve_cnt <= '0;
      end else if (cpu_gnt && starve_cnt != LIMIT) begin
         starve_cnt <= starve_cnt + 4'd1;
      end
   end

   // Command register: fields are captured only in the grant cycle and
   // otherwise hold, so only mem_req_o drops when there is no grant.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         mem_req_o   <= 1'b0;
         mem_we_o    <= 1'b0;
         mem_addr_o  <= '0;
         mem_wdata_o <= '0;
         mem_op_o    <= '0;
      end else begin
         mem_req_o <= cpu_gnt | ext_gnt;
         if (cpu_gnt) begin
            mem_we_o    <= cpu_we_i;
            mem_addr_o  <= cpu_addr_i;
            mem_wdata_o <= cpu_wdata_i;
            mem_op_o    <= cpu_mem_op_i;
         end else if (ext_gnt) begin
            mem_we_o    <= ext_we_i;
            mem_addr_o  <= ext_addr_i;
            mem_wdata_o <= ext_wdata_i;
            mem_op_o    <= ext_mem_op_i;
         end
      end
   end

   // Owner tags travel alongside the LSU pipeline. Stage 0 is visible in the
   // cycle mem_req_o is high; the registered rvalid adds the final cycle so it
   // lines up with mem_rdata_i.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         tag_vld <= '0;
         tag_own <= '0;
      end else begin
         tag_vld[0] <= load_issue;
         tag_own[0] <= ext_gnt;
         for (int i = 1; i < RD_LAT; i++) begin
            tag_vld[i] <= tag_vld[i-1];
            tag_own[i] <= tag_own[i-1];
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cpu_rvalid_q <= 1'b0;
         ext_rvalid_q <= 1'b0;
         cpu_rdata_q  <= '0;
         ext_rdata_q  <= '0;
      end else begin
         cpu_rvalid_q <= tag_vld[RD_LAT-1] & ~tag_own[RD_LAT-1];
         ext_rvalid_q <= tag_vld[RD_LAT-1] & tag_own[RD_LAT-1];
         if (cpu_rvalid_q) cpu_rdata_q <= mem_rdata_i;
         if (ext_rvalid_q) ext_rdata_q <= mem_rdata_i;
      end
   end

   // Load data passes straight through in the valid cycle; the held copy
   // keeps each owner's last value stable afterwards.
   assign cpu_rvalid_o = cpu_rvalid_q;
   assign ext_rvalid_o = ext_rvalid_q;
   assign cpu_rdata_o  = cpu_rvalid_q ? mem_rdata_i : cpu_rdata_q;
   assign ext_rdata_o  = ext_rvalid_q ? mem_rdata_i : ext_rdata_q;

endmodule

// File: tb/tb_lsu_port_arbiter.sv
// tb_lsu_port_arbiter: four arbiters (RD_LAT 1..4, last one with STARVE_LIMIT 1)
// share one directed stimulus; a behavioural model checks every cycle and
// literal expectations pin the key scenarios.
module tb_lsu_port_arbiter;
   localparam int NI = 4;

   typedef struct {
      int due;
      bit own;
   } ld_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic        rst;
   logic        cpu_req, cpu_we, ext_req, ext_we;
   logic [31:0] cpu_addr, cpu_wdata, ext_addr, ext_wdata;
   logic [2:0]  cpu_op, ext_op;
   logic [31:0] mem_rdata;
   assign mem_rdata = {16'hD000, cyc[15:0]};

   logic        cpu_gnt[NI], ext_gnt[NI], cpu_stall[NI], cpu_rv[NI], ext_rv[NI];
   logic        mem_req[NI], mem_we[NI];
   logic [31:0] cpu_rd[NI], ext_rd[NI], mem_addr[NI], mem_wdata[NI];
   logic [2:0]  mem_op[NI];

   for (genvar g = 0; g < NI; g++) begin : g_dut
      lsu_port_arbiter #(.RD_LAT(g + 1), .STARVE_LIMIT(g == 3 ? 1 : 4)) u_dut (
         .clk_i(clk), .rst_i(rst),
         .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr),
         .cpu_wdata_i(cpu_wdata), .cpu_mem_op_i(cpu_op),
         .ext_req_i(ext_req), .ext_we_i(ext_we), .ext_addr_i(ext_addr),
         .ext_wdata_i(ext_wdata), .ext_mem_op_i(ext_op),
         .cpu_gnt_o(cpu_gnt[g]), .ext_gnt_o(ext_gnt[g]), .cpu_stall_o(cpu_stall[g]),
         .cpu_rvalid_o(cpu_rv[g]), .ext_rvalid_o(ext_rv[g]),
         .cpu_rdata_o(cpu_rd[g]), .ext_rdata_o(ext_rd[g]),
         .mem_req_o(mem_req[g]), .mem_we_o(mem_we[g]), .mem_addr_o(mem_addr[g]),
         .mem_wdata_o(mem_wdata[g]), .mem_op_o(mem_op[g]),
         .mem_rdata_i(mem_rdata)
      );
   end

   int n_chk = 0;
   int n_fail = 0;

   task automatic chk(input string nm, input int g, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s inst%0d cyc=%0d got=%h want=%h", nm, g, cyc, act, exp);
      end
   endtask

   function automatic logic [31:0] rd_at(input int c);
      return {16'hD000, c[15:0]};
   endfunction

   function automatic int lim(input int g);
      return (g == 3) ? 1 : 4;
   endfunction

   // ---------------- behavioural model ----------------
   int          losses[NI];
   logic        em_req[NI], em_we[NI];
   logic [31:0] em_addr[NI], em_wdata[NI], hold_c[NI], hold_e[NI];
   logic [2:0]  em_op[NI];
   ld_t         pq[NI][$];
   bit          m_forced, m_cg, m_eg, m_cv, m_ev;
   ld_t         m_e;

   initial begin
      for (int g = 0; g < NI; g++) begin
         losses[g] = 0; em_req[g] = 0; em_we[g] = 0; em_addr[g] = 0;
         em_wdata[g] = 0; em_op[g] = 0; hold_c[g] = 0; hold_e[g] = 0;
      end
   end

   always @(negedge clk) begin
      for (int g = 0; g < NI; g++) begin
         if (rst) begin
            chk("r_cgnt", g, cpu_gnt[g], 0);  chk("r_egnt", g, ext_gnt[g], 0);
            chk("r_stall", g, cpu_stall[g], 0);
            chk("r_crv", g, cpu_rv[g], 0);    chk("r_erv", g, ext_rv[g], 0);
            chk("r_crd", g, cpu_rd[g], 0);    chk("r_erd", g, ext_rd[g], 0);
            chk("r_mreq", g, mem_req[g], 0);  chk("r_mwe", g, mem_we[g], 0);
            chk("r_maddr", g, mem_addr[g], 0); chk("r_mwd", g, mem_wdata[g], 0);
            chk("r_mop", g, mem_op[g], 0);
            losses[g] = 0; em_req[g] = 0; em_we[g] = 0; em_addr[g] = 0;
            em_wdata[g] = 0; em_op[g] = 0; hold_c[g] = 0; hold_e[g] = 0;
            pq[g].delete();
         end else begin
            m_forced = ext_req && (losses[g] == lim(g));
            m_cg = cpu_req && !m_forced;
            m_eg = ext_req && (!cpu_req || m_forced);
            chk("m_cgnt", g, cpu_gnt[g], m_cg);
            chk("m_egnt", g, ext_gnt[g], m_eg);
            chk("m_stall", g, cpu_stall[g], cpu_req && !m_cg);
            chk("m_mreq", g, mem_req[g], em_req[g]);
            chk("m_mwe", g, mem_we[g], em_we[g]);
            chk("m_maddr", g, mem_addr[g], em_addr[g]);
            chk("m_mwd", g, mem_wdata[g], em_wdata[g]);
            chk("m_mop", g, mem_op[g], em_op[g]);
            m_cv = 0; m_ev = 0;
            if (pq[g].size() > 0 && pq[g][0].due == cyc) begin
               m_e = pq[g].pop_front();
               if (m_e.own) m_ev = 1; else m_cv = 1;
            end
            if (m_cv) hold_c[g] = mem_rdata;
            if (m_ev) hold_e[g] = mem_rdata;
            chk("m_crv", g, cpu_rv[g], m_cv);
            chk("m_erv", g, ext_rv[g], m_ev);
            chk("m_crd", g, cpu_rd[g], hold_c[g]);
            chk("m_erd", g, ext_rd[g], hold_e[g]);
            // advance to the next cycle
            if (!ext_req || m_eg) losses[g] = 0;
            else if (m_cg && losses[g] < lim(g)) losses[g]++;
            em_req[g] = m_cg || m_eg;
            if (m_cg) begin
               em_we[g] = cpu_we; em_addr[g] = cpu_addr; em_wdata[g] = cpu_wdata; em_op[g] = cpu_op;
               if (!cpu_we) pq[g].push_back('{due: cyc + 2 + g, own: 1'b0});
            end else if (m_eg) begin
               em_we[g] = ext_we; em_addr[g] = ext_addr; em_wdata[g] = ext_wdata; em_op[g] = ext_op;
               if (!ext_we) pq[g].push_back('{due: cyc + 2 + g, own: 1'b1});
            end
         end
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   task automatic idle();
      cpu_req = 0;
      ext_req = 0;
   endtask

   task automatic cpu_cmd(input logic we, input logic [31:0] a, input logic [31:0] d, input logic [2:0] op);
      cpu_req = 1; cpu_we = we; cpu_addr = a; cpu_wdata = d; cpu_op = op;
   endtask

   task automatic ext_cmd(input logic we, input logic [31:0] a, input logic [31:0] d, input logic [2:0] op);
      ext_req = 1; ext_we = we; ext_addr = a; ext_wdata = d; ext_op = op;
   endtask

   int t0;

   initial begin
      rst = 1;
      idle();
      cpu_we = 0; cpu_addr = 0; cpu_wdata = 0; cpu_op = 0;
      ext_we = 0; ext_addr = 0; ext_wdata = 0; ext_op = 0;
      repeat (3) @(posedge clk);
      mid();
      chk("rst_mreq", 0, mem_req[0], 0);
      chk("rst_crd", 0, cpu_rd[0], 0);

      // cpu load stream, first grant in the first cycle out of reset
      nxt(); rst = 0; cpu_cmd(0, 32'h10, 0, 3'd2); t0 = cyc;
      mid(); chk("a_gnt", 0, cpu_gnt[0], 1); chk("a_stall", 0, cpu_stall[0], 0);
      nxt(); cpu_cmd(0, 32'h14, 0, 3'd2);
      mid(); chk("a_mreq", 0, mem_req[0], 1); chk("a_maddr", 0, mem_addr[0], 32'h10);
      nxt(); cpu_cmd(0, 32'h18, 0, 3'd2);
      mid(); chk("a_rv0", 0, cpu_rv[0], 1); chk("a_rd0", 0, cpu_rd[0], rd_at(t0 + 2));
      nxt(); idle();
      mid(); chk("a_rv1", 0, cpu_rv[0], 1); chk("a_rd1", 0, cpu_rd[0], rd_at(t0 + 3));
      chk("a_maddr2", 0, mem_addr[0], 32'h18);
      nxt();
      mid(); chk("a_rv2", 0, cpu_rv[0], 1); chk("a_rd2", 0, cpu_rd[0], rd_at(t0 + 4));
      chk("a_mreq0", 0, mem_req[0], 0); chk("a_lat3", 2, cpu_rv[2], 1);
      nxt();
      mid(); chk("a_rvoff", 0, cpu_rv[0], 0); chk("a_rdhold", 0, cpu_rd[0], rd_at(t0 + 4));

      // ext store while cpu idle
      nxt(); ext_cmd(1, 32'h7000, 32'hDEADBEEF, 3'd2);
      mid(); chk("b_egnt", 0, ext_gnt[0], 1); chk("b_cgnt", 0, cpu_gnt[0], 0);
      nxt(); idle();
      mid(); chk("b_mreq", 0, mem_req[0], 1); chk("b_mwe", 0, mem_we[0], 1);
      chk("b_maddr", 0, mem_addr[0], 32'h7000); chk("b_mwd", 0, mem_wdata[0], 32'hDEADBEEF);
      chk("b_mop", 0, mem_op[0], 3'd2);
      nxt();
      mid(); chk("b_mreq0", 0, mem_req[0], 0); chk("b_mhold", 0, mem_addr[0], 32'h7000);
      chk("b_norv", 0, ext_rv[0], 0);

      // starvation: both requesting continuously
      nxt(); cpu_cmd(0, 32'h100, 0, 3'd2); ext_cmd(0, 32'h200, 0, 3'd1);
      for (int k = 0; k < 12; k++) begin
         if (k > 0) nxt();
         mid();
         chk("c_egnt", 0, ext_gnt[0], (k % 5) == 4);
         chk("c_stall", 0, cpu_stall[0], (k % 5) == 4);
         chk("c_cgnt", 0, cpu_gnt[0], (k % 5) != 4);
         chk("c_lim1", 3, ext_gnt[3], (k % 2) == 1);
         if (k == 5) chk("c_maddr", 0, mem_addr[0], 32'h200);
      end
      nxt(); idle(); mid();

      // dropping ext_req clears the starvation count
      nxt(); cpu_cmd(0, 32'h300, 0, 3'd2); ext_cmd(0, 32'h400, 0, 3'd2); mid();
      nxt(); mid();
      nxt(); mid();
      nxt(); ext_req = 0; mid();
      for (int k = 0; k < 5; k++) begin
         nxt(); ext_req = 1;
         mid(); chk("d_egnt", 0, ext_gnt[0], k == 4);
      end
      nxt(); idle(); mid();

      // interleaved owners, RD_LAT = 3
      nxt(); cpu_cmd(0, 32'h20, 0, 3'd2); t0 = cyc; mid();
      nxt(); cpu_req = 0; ext_cmd(0, 32'h24, 0, 3'd2); mid();
      nxt(); ext_req = 0; cpu_cmd(0, 32'h28, 0, 3'd2); mid();
      nxt(); idle(); mid();
      nxt();
      mid(); chk("e_crv0", 2, cpu_rv[2], 1); chk("e_crd0", 2, cpu_rd[2], rd_at(t0 + 4));
      chk("e_erv0", 2, ext_rv[2], 0);
      nxt();
      mid(); chk("e_erv", 2, ext_rv[2], 1); chk("e_erd", 2, ext_rd[2], rd_at(t0 + 5));
      chk("e_crv1", 2, cpu_rv[2], 0); chk("e_crdh", 2, cpu_rd[2], rd_at(t0 + 4));
      nxt();
      mid(); chk("e_crv2", 2, cpu_rv[2], 1); chk("e_crd2", 2, cpu_rd[2], rd_at(t0 + 6));
      chk("e_erdh", 2, ext_rd[2], rd_at(t0 + 5));
      nxt(); mid();

      // store then load: only the load returns
      nxt(); cpu_cmd(1, 32'h30, 32'h12345678, 3'd2); mid();
      nxt(); cpu_cmd(0, 32'h34, 0, 3'd2); mid();
      nxt(); idle();
      mid(); chk("g_mwe", 0, mem_we[0], 0); chk("g_strv", 0, cpu_rv[0], 0);
      nxt();
      mid(); chk("g_ldrv", 0, cpu_rv[0], 1);
      repeat (4) begin nxt(); mid(); end

      // reset mid-flight, RD_LAT = 2
      nxt(); cpu_cmd(0, 32'h50, 0, 3'd2); t0 = cyc; mid();
      nxt(); cpu_cmd(0, 32'h54, 0, 3'd2); mid();
      nxt(); cpu_req = 0; rst = 1; ext_cmd(0, 32'h58, 0, 3'd2);
      mid(); chk("f_egnt", 1, ext_gnt[1], 0); chk("f_mreq", 1, mem_req[1], 0);
      chk("f_maddr", 1, mem_addr[1], 0); chk("f_crd", 1, cpu_rd[1], 0);
      nxt(); rst = 0; idle();
      mid(); chk("f_norv0", 1, cpu_rv[1], 0);
      nxt();
      mid(); chk("f_norv1", 1, cpu_rv[1], 0);
      nxt(); cpu_cmd(0, 32'h60, 0, 3'd2); t0 = cyc;
      mid(); chk("f_gnt", 1, cpu_gnt[1], 1);
      nxt(); idle(); mid();
      nxt(); mid();
      nxt();
      mid(); chk("f_rv", 1, cpu_rv[1], 1); chk("f_rd", 1, cpu_rd[1], rd_at(t0 + 3));

      repeat (6) begin nxt(); mid(); end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/lsu_port_arbiter.md
LSU_PORT_ARBITER -- requirements
Module: lsu_port_arbiter

Interface
REQ-001 Parameter RD_LAT, default 1, means the cycles from mem_req_o high to mem_rdata_i valid; the legal range is 1..4.
REQ-002 Parameter STARVE_LIMIT, default 4, means the maximum consecutive cycles ext may lose arbitration to cpu; the legal range is 1..15.
REQ-003 Clock and reset are decided: one clock; reset is asynchronous and active-high.
REQ-004 clk_i  in  1  clock; all state updates on the rising edge.
REQ-005 rst_i  in  1  asynchronous active-high reset.
REQ-006 cpu_req_i  in  1  MEM-stage access request.
REQ-007 cpu_we_i  in  1  1 = store, 0 = load.
REQ-008 cpu_addr_i  in  32  byte address.
REQ-009 cpu_wdata_i  in  32  store data.
REQ-010 cpu_mem_op_i  in  3  size/sign code, passed through unchanged.
REQ-011 ext_req_i, ext_we_i, ext_addr_i, ext_wdata_i, ext_mem_op_i  in  1/1/32/32/3  debug/loader requester, same meaning as the cpu_* ports.
REQ-012 cpu_gnt_o, ext_gnt_o  out  1  request accepted this cycle (combinational).
REQ-013 cpu_stall_o  out  1  = cpu_req_i & ~cpu_gnt_o; the pipeline freezes while this is high.
REQ-014 cpu_rvalid_o, ext_rvalid_o  out  1  one-cycle load-data-valid pulse to the owner.
REQ-015 cpu_rdata_o, ext_rdata_o  out  32  load data, valid with the matching rvalid.
REQ-016 mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_op_o  out  1/1/32/32/3  registered command to the LSU.
REQ-017 mem_rdata_i  in  32  LSU load data, valid exactly RD_LAT cycles after mem_req_o & ~mem_we_o.

Function
REQ-018 At most one grant shall be asserted per cycle.
REQ-019 A requester shall hold req and all its fields stable until it sees gnt; the arbiter shall sample those fields only in the grant cycle.
REQ-020 Default priority: cpu_gnt_o = cpu_req_i, unless a forced-ext condition exists.
REQ-021 ext_gnt_o = ext_req_i & (~cpu_req_i | starve_cnt == STARVE_LIMIT).
REQ-022 When ext is forced, cpu_gnt_o shall be 0 and cpu_stall_o shall be 1.
REQ-023 starve_cnt is 4 bits.
  - It increments in any cycle where ext_req_i is high and cpu_gnt_o is high.
  - It clears to 0 on ext_gnt_o or when ext_req_i is low.
  - It saturates at STARVE_LIMIT.
REQ-024 Grant in cycle N shall drive the granted command into mem_* registers, giving mem_req_o = 1 in cycle N+1.
  - With no grant in cycle N, mem_req_o = 0 in cycle N+1.
  - Other mem_* outputs then hold their previous values.
REQ-025 Throughput: one grant per cycle is allowed back-to-back, with no bubble and no limit on outstanding loads beyond RD_LAT.
REQ-026 An owner-tag shift register of depth RD_LAT shall record {valid, owner} for each issued load.
  - Stores shall enter valid = 0.
REQ-027 When the tag reaches the output, the owner's rvalid shall pulse for exactly one cycle at cycle N+1+RD_LAT.
  - The owner's rdata shall equal mem_rdata_i in that cycle.
  - The non-owner's rdata shall hold its last value.
REQ-028 Stores shall produce no rvalid.
REQ-029 Read-data ordering shall equal issue order; loads from different owners may interleave freely.
REQ-030 Simultaneous cpu_req_i and ext_req_i with starve_cnt < STARVE_LIMIT shall grant cpu.
REQ-031 A forced ext grant shall last exactly one cycle; the next cycle reverts to cpu priority with starve_cnt = 0.
REQ-032 The address range is not checked; an out-of-range address is the LSU's concern.

Reset
REQ-033 While rst_i is high, all state and outputs shall be 0.
  - This covers mem_*, rvalid, rdata, starve_cnt and every tag valid bit.
  - cpu_gnt_o and ext_gnt_o shall be forced to 0.
REQ-034 Reset mid-transaction shall discard all in-flight loads; no rvalid shall be produced for any load issued before reset deassertion.
REQ-035 The first grant is possible in the first cycle with rst_i low.

Verification
REQ-036 CPU load stream: cpu load addr 0x10, 0x14, 0x18 on consecutive cycles, RD_LAT = 1.
  - Required: mem_req_o high for 3 cycles.
  - Required: cpu_rvalid_o pulses in cycles 2, 3, 4 with data in order; cpu_stall_o stays 0.
REQ-037 Idle-CPU ext access: ext store addr 0x7000 wdata 0xDEADBEEF with cpu_req_i = 0.
  - Required: ext_gnt_o in the same cycle.
  - Required: next cycle mem_we_o = 1, mem_addr_o = 0x7000, mem_wdata_o = 0xDEADBEEF; no rvalid.
REQ-038 Starvation with STARVE_LIMIT = 4: cpu_req_i and ext_req_i (load) held high continuously.
  - Required: cpu granted in cycles 0-3, ext granted in cycle 4 with cpu_stall_o = 1, cpu granted again in cycle 5.
  - Required: the pattern repeats every 5 cycles.
REQ-039 Interleaved owners with RD_LAT = 3: cpu load, ext load, cpu load issued back-to-back.
  - Required: rvalid order is cpu, ext, cpu in cycles 4, 5, 6, each carrying its own mem_rdata_i.
REQ-040 Reset mid-flight: rst_i pulsed 1 cycle after 2 loads are issued with RD_LAT = 2.
  - Required: no cpu_rvalid_o or ext_rvalid_o after reset; all outputs 0 during reset; a new load after reset returns normally.
